// File: rtl/udp_conn_filter.sv
// Ingress connection filter: looks up a key taken from the first beat of each packet, buffers the
// packet until the ordered result returns, then forwards it tagged with the connection id or discards it.
module udp_conn_filter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEY_WIDTH  = 32,
    parameter int KEY_LSB    = 0,
    parameter int RESP_WIDTH = 18,
    parameter int DATA_DEPTH = 64,
    parameter int META_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_lookup_valid,
    input  logic                  m_lookup_ready,
    output logic [KEY_WIDTH-1:0]  m_lookup_key,
    input  logic                  s_lookup_valid,
    input  logic                  s_lookup_hit,
    input  logic [RESP_WIDTH-1:0] s_lookup_resp,
    output logic                  s_lookup_ready,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [RESP_WIDTH-1:0] m_axis_tuser,
    output logic [31:0]           pass_count,
    output logic [31:0]           drop_count
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int MAW = $clog2(META_DEPTH);
    localparam logic [DAW:0] DATA_FULL = (DAW+1)'(DATA_DEPTH);
    localparam logic [MAW:0] META_FULL = (MAW+1)'(META_DEPTH);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
    state_t state, state_nxt;

    logic                  sop;
    logic [MAW:0]          pending;

    logic [DATA_WIDTH:0]   data_mem [DATA_DEPTH];
    logic [DAW-1:0]        d_wr, d_rd;
    logic [DAW:0]          d_cnt;
    logic [RESP_WIDTH:0]   res_mem [META_DEPTH];
    logic [MAW-1:0]        r_wr, r_rd;
    logic [MAW:0]          r_cnt;

    logic data_full, data_empty, res_full, res_empty, room;
    logic accept, issue, d_push, d_pop, r_push, r_pop;
    logic [DATA_WIDTH:0]   d_head;
    logic [RESP_WIDTH:0]   r_head;

    assign data_full  = d_cnt == DATA_FULL;
    assign data_empty = d_cnt == '0;
    assign res_full   = r_cnt == META_FULL;
    assign res_empty  = r_cnt == '0;
    assign room       = pending < META_FULL;

    // A first beat is only accepted together with its lookup handshake; both are held off in reset.
    assign s_axis_tready  = rst_n && !data_full && (!sop || (m_lookup_ready && room));
    assign m_lookup_valid = rst_n && s_axis_tvalid && sop && !data_full && room;
    assign m_lookup_key   = s_axis_tdata[KEY_LSB +: KEY_WIDTH];
    assign s_lookup_ready = 1'b1;

    assign accept = s_axis_tvalid && s_axis_tready;
    assign issue  = m_lookup_valid && m_lookup_ready;
    assign d_push = accept;
    assign r_push = s_lookup_valid && !res_full;
    assign d_head = data_mem[d_rd];
    assign r_head = res_mem[r_rd];

    always_comb begin
        state_nxt     = state;
        r_pop         = 1'b0;
        d_pop         = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state)
            IDLE: begin
                if (!res_empty) begin
                    r_pop     = 1'b1;
                    state_nxt = r_head[RESP_WIDTH] ? PASS : DROP;
                end
            end
            PASS: begin
                m_axis_tvalid = !data_empty;
                d_pop         = m_axis_tvalid && m_axis_tready;
                if (d_pop && d_head[0]) state_nxt = IDLE;
            end
            DROP: begin
                d_pop = !data_empty;
                if (d_pop && d_head[0]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate the head so nothing stale leaks out while no beat is being presented.
    assign m_axis_tdata = m_axis_tvalid ? d_head[DATA_WIDTH:1] : '0;
    assign m_axis_tlast = m_axis_tvalid && d_head[0];

    always_ff @(posedge clk) begin
        if (d_push) data_mem[d_wr] <= {s_axis_tdata, s_axis_tlast};
        if (r_push) res_mem[r_wr]  <= {s_lookup_hit, s_lookup_resp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sop          <= 1'b1;
            pending      <= '0;
            d_wr         <= '0;
            d_rd         <= '0;
            d_cnt        <= '0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
            m_axis_tuser <= '0;
            pass_count   <= '0;
            drop_count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) sop <= s_axis_tlast;
            case ({issue, r_pop})
                2'b10:   pending <= pending + (MAW+1)'(1);
                2'b01:   pending <= pending - (MAW+1)'(1);
                default: pending <= pending;
            endcase
            if (d_push) d_wr <= d_wr + DAW'(1);
            if (d_pop)  d_rd <= d_rd + DAW'(1);
            d_cnt <= d_cnt + (DAW+1)'(d_push) - (DAW+1)'(d_pop);
            if (r_push) r_wr <= r_wr + MAW'(1);
            if (r_pop)  r_rd <= r_rd + MAW'(1);
            r_cnt <= r_cnt + (MAW+1)'(r_push) - (MAW+1)'(r_pop);
            if (r_pop) m_axis_tuser <= r_head[RESP_WIDTH-1:0];
            if (state == PASS && d_pop && d_head[0]) pass_count <= pass_count + 32'd1;
            if (state == DROP && d_pop && d_head[0]) drop_count <= drop_count + 32'd1;
        end
    end

    // The pending limit keeps the result FIFO from overflowing; a push while full is dropped.
    res_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(s_lookup_valid && res_full));

endmodule

// File: tb/tb_udp_conn_filter.sv
// Randomized and directed bench for udp_conn_filter against a packet-level reference model.
module tb_udp_conn_filter;
    localparam int DW = 64, KW = 32, RW = 18;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          m_lookup_valid, m_lookup_ready = 1'b1;
    logic [KW-1:0] m_lookup_key;
    logic          s_lookup_valid = 1'b0, s_lookup_hit = 1'b0, s_lookup_ready;
    logic [RW-1:0] s_lookup_resp = '0;
    logic          m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [RW-1:0] m_axis_tuser;
    logic [31:0]   pass_count, drop_count;

    udp_conn_filter dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_lookup_valid(m_lookup_valid), .m_lookup_ready(m_lookup_ready), .m_lookup_key(m_lookup_key),
        .s_lookup_valid(s_lookup_valid), .s_lookup_hit(s_lookup_hit), .s_lookup_resp(s_lookup_resp),
        .s_lookup_ready(s_lookup_ready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .pass_count(pass_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic last; logic [RW-1:0] user; } beat_t;
    typedef struct { int due; logic hit; logic [RW-1:0] resp; } rsp_t;

    beat_t       exp_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] key_q[$];
    int          issue_cyc[$];
    bit          ovr_hit  [logic [31:0]];
    logic [RW-1:0] ovr_resp [logic [31:0]];

    int n_chk = 0, n_err = 0;
    int cyc = 0, lat = 2, rdy_mode = 1;
    int exp_pass = 0, exp_drop = 0, acc_beats = 0, out_beats = 0, first_out = -1;
    bit sender_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Connection table: explicit entries, otherwise a fixed rule on the key.
    function automatic bit ref_hit(input logic [31:0] k);
        if (ovr_hit.exists(k)) return ovr_hit[k];
        return (k % 3) != 0;
    endfunction
    function automatic logic [RW-1:0] ref_resp(input logic [31:0] k);
        if (ovr_resp.exists(k)) return ovr_resp[k];
        return k[RW-1:0] ^ 18'h2A5A5;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Lookup responder with fixed latency; responses stay in issue order.
    always @(posedge clk) begin
        rsp_t r;
        #1;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            s_lookup_valid = 1'b1;
            s_lookup_hit   = r.hit;
            s_lookup_resp  = r.resp;
        end else begin
            s_lookup_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        logic [31:0] k;
        if (rst_n) begin
            if (m_lookup_valid && m_lookup_ready) begin
                issue_cyc.push_back(cyc);
                k = (key_q.size() != 0) ? key_q.pop_front() : 32'hDEADBEEF;
                chk("lookup_key", 64'(m_lookup_key), 64'(k));
                rsp_q.push_back('{due: cyc + lat, hit: ref_hit(m_lookup_key), resp: ref_resp(m_lookup_key)});
            end
            if (s_axis_tvalid && s_axis_tready) acc_beats++;
            if (m_axis_tvalid && first_out < 0) first_out = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                out_beats++;
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    chk("tdata", m_axis_tdata, b.data);
                    chk("tlast", 64'(m_axis_tlast), 64'(b.last));
                    chk("tuser", 64'(m_axis_tuser), 64'(b.user));
                end
            end
        end
    end

    task automatic wait_acc();
        int t = 0;
        @(negedge clk);
        while (!s_axis_tready && t < 3000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 3000) chk("accept_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [31:0] key, input int nb);
        logic [DW-1:0] d;
        bit h;
        h = ref_hit(key);
        key_q.push_back(key);
        if (h) exp_pass++; else exp_drop++;
        for (int i = 0; i < nb; i++) begin
            d = (i == 0) ? {$urandom(), key} : {$urandom(), $urandom()};
            if (h) exp_q.push_back('{data: d, last: (i == nb - 1), user: ref_resp(key)});
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tlast  = (i == nb - 1);
            wait_acc();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", 64'(t >= 20000), 64'd0);
        repeat (100) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        issue_cyc.delete();
        acc_beats = 0;
        out_beats = 0;
        first_out = -1;
    endtask

    task automatic rst_on();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        key_q.delete();
        exp_pass = 0;
        exp_drop = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_on();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_pass"}, 64'(pass_count), 64'(exp_pass));
        chk({tag, "_drop"}, 64'(drop_count), 64'(exp_drop));
    endtask

    task automatic wait_sender();
        for (int t = 0; t < 5000 && !sender_done; t++) @(posedge clk);
        chk("sender_done", 64'(sender_done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        // Reset values, with a first beat offered while reset is held.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'h1234_5678_0A00_0001;
        #12;
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_lookup_valid", 64'(m_lookup_valid), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tdata", m_axis_tdata, 64'd0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
        chk("rst_pass", 64'(pass_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("lookup_ready_tied", 64'(s_lookup_ready), 64'd1);
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();

        // Hit, 3 beats, first egress beat four cycles after the first beat is accepted.
        ovr_hit[32'h0A000001]  = 1'b1;
        ovr_resp[32'h0A000001] = 18'h10001;
        send_pkt(32'h0A000001, 3);
        drain();
        chk("hit_latency", 64'(first_out - issue_cyc[0]), 64'd4);
        chk("hit_pass", 64'(pass_count), 64'd1);
        check_counts("hit");

        // Miss, 4 beats: nothing comes out.
        ovr_hit[32'h0B000002]  = 1'b0;
        ovr_resp[32'h0B000002] = 18'h00777;
        clear_stats();
        send_pkt(32'h0B000002, 4);
        drain();
        chk("miss_no_out", 64'(out_beats), 64'd0);
        chk("miss_drop", 64'(drop_count), 64'd1);
        check_counts("miss");

        // Six back-to-back packets: hit, miss, hit, hit, miss, single-beat hit.
        do_reset();
        begin
            bit hp[6] = '{1, 0, 1, 1, 0, 1};
            int ln[6] = '{3, 2, 4, 2, 5, 1};
            for (int p = 0; p < 6; p++) begin
                ovr_hit[32'h100 + p]  = hp[p];
                ovr_resp[32'h100 + p] = 18'(32'h20000 + p * 17);
            end
            for (int p = 0; p < 6; p++) send_pkt(32'h100 + p, ln[p]);
        end
        drain();
        chk("mix_pass", 64'(pass_count), 64'd4);
        chk("mix_drop", 64'(drop_count), 64'd2);
        check_counts("mix");

        // Egress stalled while 100 beats are offered: ingress fills exactly the data FIFO.
        do_reset();
        rdy_mode = 0;
        @(posedge clk);
        #2;
        for (int p = 0; p < 10; p++) ovr_hit[32'h2000 + p] = 1'b1;
        sender_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 10; p++) send_pkt(32'h2000 + p, 10);
                sender_done = 1'b1;
            end
        join_none
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("bp_beats_in", 64'(acc_beats), 64'd64);
        chk("bp_tready_low", 64'(s_axis_tready), 64'd0);
        chk("bp_no_out", 64'(out_beats), 64'd0);
        rdy_mode = 1;
        wait_sender();
        drain();
        chk("bp_beats_out", 64'(out_beats), 64'd100);
        check_counts("bp");

        // Slow lookups: the ninth first beat waits for the first result to be consumed.
        do_reset();
        lat = 20;
        for (int p = 0; p < 10; p++) ovr_hit[32'h3000 + p] = 1'b1;
        sender_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 10; p++) send_pkt(32'h3000 + p, 1);
                sender_done = 1'b1;
            end
        join_none
        for (int t = 0; t < 300 && issue_cyc.size() < 8; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("meta_issued", 64'(issue_cyc.size()), 64'd8);
        chk("meta_lookup_stall", 64'(m_lookup_valid), 64'd0);
        chk("meta_tready_stall", 64'(s_axis_tready), 64'd0);
        wait_sender();
        chk("meta_ninth_issue", 64'(issue_cyc[8] - issue_cyc[0]), 64'd22);
        drain();
        lat = 2;
        check_counts("meta");

        // Reset during beat 3 of a 5-beat packet.
        do_reset();
        send_pkt(32'h0A000001, 2);
        drain();
        chk("pre_rst_tuser", 64'(m_axis_tuser), 64'h10001);
        ovr_hit[32'h0C000003] = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {32'h55, 32'h0C000003};
        s_axis_tlast  = 1'b0;
        key_q.push_back(32'h0C000003);
        wait_acc();
        s_axis_tdata = {$urandom(), $urandom()};
        wait_acc();
        s_axis_tdata = {$urandom(), $urandom()};
        #2;
        rst_on();
        #1;
        chk("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("mid_rst_lookup_valid", 64'(m_lookup_valid), 64'd0);
        chk("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_m_tdata", m_axis_tdata, 64'd0);
        chk("mid_rst_tuser", 64'(m_axis_tuser), 64'd0);
        chk("mid_rst_pass", 64'(pass_count), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        send_pkt(32'h0A000001, 2);
        chk("post_rst_issue", 64'(issue_cyc.size()), 64'd1);
        drain();
        check_counts("post_rst");

        // Random traffic with random egress backpressure.
        do_reset();
        rdy_mode = 2;
        lat = 3;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom(), $urandom_range(1, 6));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rdy_mode = 1;
        check_counts("rand");
        chk("rand_left", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
